// File: rtl/sys_timer_pkg.sv
// Shared definitions for the interval-timer tick scheduler: timer register
// map, control/status bit positions, canned control words and FSM states.
package sys_timer_pkg;

    // Timer s1 register addresses
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    // Control register bit positions
    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    // Status register bit positions
    localparam int STATUS_TO_BIT  = 0;
    localparam int STATUS_RUN_BIT = 1;

    // ITO | CONT | START: continuous mode with interrupt enabled
    localparam logic [15:0] CTRL_START_WORD = 16'((1 << CTRL_ITO_BIT) |
                                                  (1 << CTRL_CONT_BIT) |
                                                  (1 << CTRL_START_BIT));
    localparam logic [15:0] CTRL_STOP_WORD  = 16'(1 << CTRL_STOP_BIT);
    // Any write to status clears TO; zero keeps it obvious on the bus
    localparam logic [15:0] STATUS_ACK_WORD = 16'h0000;

    // Number of START attempts before giving up
    localparam logic [1:0] MAX_START_TRIES = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RD_STAT,
        S_CHK,
        S_RUN,
        S_ACK,
        S_ACK_WAIT,
        S_STOP,
        S_HALT
    } sched_state_t;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counts scheduler ticks and fires once every div ticks
// (div of 0 behaves as 1). Disabled channels hold themselves preloaded so the
// first event after enabling lands on the div-th tick.
module tick_div_channel #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             fire
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] reload_val;
    logic             fire_reg;

    // Reload value is max(div,1)-1; a new div is only picked up here
    always_comb begin
        reload_val = (div == '0) ? '0 : div - DIV_W'(1);
    end

    // Advance the counter on each tick; fire is a registered one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            fire_reg <= 1'b0;
        end else begin
            fire_reg <= 1'b0;
            if (advance) begin
                if (!en) begin
                    cnt_reg <= reload_val;
                end else if (cnt_reg == '0) begin
                    fire_reg <= 1'b1;
                    cnt_reg  <= reload_val;
                end else begin
                    cnt_reg <= cnt_reg - DIV_W'(1);
                end
            end
        end
    end

    assign fire = fire_reg;

endmodule

// File: rtl/sys_timer_tick_scheduler.sv
// Avalon-MM master for the Nios interval timer: programs the period, starts
// continuous interrupt mode, verifies RUN, acknowledges every timeout with a
// one-cycle tick, and fans the ticks out to NUM_CH divider channels.
module sys_timer_tick_scheduler
    import sys_timer_pkg::*;
#(
    parameter logic [31:0] PERIOD = 32'h0007_A11F,
    parameter int          NUM_CH = 4,
    parameter int          DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    output logic [2:0]              tmr_address,
    output logic                    tmr_chipselect,
    output logic                    tmr_write_n,
    output logic [15:0]             tmr_writedata,
    input  logic [15:0]             tmr_readdata,
    input  logic                    tmr_irq,
    output logic                    tick,
    output logic [NUM_CH-1:0]       ch_event,
    output logic [31:0]             tick_count,
    output logic                    running,
    output logic                    fault
);

    sched_state_t state_reg, state_next;
    logic [1:0]   retry_reg, retry_next, retry_inc;
    logic         running_reg, running_next;
    logic         fault_reg, fault_next;
    logic         tick_reg, tick_next;
    logic [31:0]  tick_count_reg;

    logic [2:0]   addr_reg, addr_next;
    logic         cs_reg, cs_next;
    logic         write_n_reg, write_n_next;
    logic [15:0]  wdata_reg, wdata_next;

    // Only the RUN bit of status matters for start verification
    logic         unused_readdata_bits;
    assign unused_readdata_bits = ^{tmr_readdata[15:STATUS_RUN_BIT+1],
                                    tmr_readdata[STATUS_RUN_BIT-1:0]};

    // Next-state logic: programming, verification with retries, run/ack loop
    always_comb begin
        state_next   = state_reg;
        retry_next   = retry_reg;
        running_next = running_reg;
        fault_next   = fault_reg;
        retry_inc    = retry_reg + 2'd1;
        unique case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_WR_PL;
                    retry_next = '0;
                end
            end
            S_WR_PL:   state_next = S_WR_PH;
            S_WR_PH:   state_next = S_WR_CTRL;
            S_WR_CTRL: state_next = S_RD_STAT;
            S_RD_STAT: state_next = S_CHK;
            S_CHK: begin
                if (tmr_readdata[STATUS_RUN_BIT]) begin
                    running_next = 1'b1;
                    state_next   = S_RUN;
                end else if (retry_inc < MAX_START_TRIES) begin
                    retry_next = retry_inc;
                    state_next = S_WR_CTRL;
                end else begin
                    retry_next = retry_inc;
                    fault_next = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_RUN: begin
                // A pending timeout is acknowledged before honouring a stop
                if (tmr_irq) begin
                    state_next = S_ACK;
                end else if (!enable) begin
                    running_next = 1'b0;
                    state_next   = S_STOP;
                end
            end
            S_ACK:      state_next = S_ACK_WAIT;
            S_ACK_WAIT: state_next = S_RUN;
            S_STOP:     state_next = S_IDLE;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_IDLE;
        endcase
    end

    // Bus cycle decode from the upcoming state so the bus pins are registered
    always_comb begin
        addr_next    = ADDR_STATUS;
        cs_next      = 1'b0;
        write_n_next = 1'b1;
        wdata_next   = '0;
        case (state_next)
            S_WR_PL: begin
                addr_next = ADDR_PERIOD_L; cs_next = 1'b1; write_n_next = 1'b0;
                wdata_next = PERIOD[15:0];
            end
            S_WR_PH: begin
                addr_next = ADDR_PERIOD_H; cs_next = 1'b1; write_n_next = 1'b0;
                wdata_next = PERIOD[31:16];
            end
            S_WR_CTRL: begin
                addr_next = ADDR_CONTROL; cs_next = 1'b1; write_n_next = 1'b0;
                wdata_next = CTRL_START_WORD;
            end
            S_RD_STAT: begin
                addr_next = ADDR_STATUS; cs_next = 1'b1;
            end
            S_ACK: begin
                addr_next = ADDR_STATUS; cs_next = 1'b1; write_n_next = 1'b0;
                wdata_next = STATUS_ACK_WORD;
            end
            S_STOP: begin
                addr_next = ADDR_CONTROL; cs_next = 1'b1; write_n_next = 1'b0;
                wdata_next = CTRL_STOP_WORD;
            end
            default: ;
        endcase
    end

    assign tick_next = (state_next == S_ACK);

    // State, status and bus output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            retry_reg      <= '0;
            running_reg    <= 1'b0;
            fault_reg      <= 1'b0;
            tick_reg       <= 1'b0;
            tick_count_reg <= '0;
            addr_reg       <= ADDR_STATUS;
            cs_reg         <= 1'b0;
            write_n_reg    <= 1'b1;
            wdata_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            retry_reg   <= retry_next;
            running_reg <= running_next;
            fault_reg   <= fault_next;
            tick_reg    <= tick_next;
            if (tick_next) begin
                tick_count_reg <= tick_count_reg + 32'd1;
            end
            addr_reg    <= addr_next;
            cs_reg      <= cs_next;
            write_n_reg <= write_n_next;
            wdata_reg   <= wdata_next;
        end
    end

    // Divider channels advance on the same edge that raises tick
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tick_div_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .advance(tick_next),
            .en     (ch_en[gi]),
            .div    (ch_div[gi*DIV_W +: DIV_W]),
            .fire   (ch_event[gi])
        );
    end

    assign tmr_address    = addr_reg;
    assign tmr_chipselect = cs_reg;
    assign tmr_write_n    = write_n_reg;
    assign tmr_writedata  = wdata_reg;
    assign tick           = tick_reg;
    assign tick_count     = tick_count_reg;
    assign running        = running_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_sys_timer_tick_scheduler.sv
// Bench for sys_timer_tick_scheduler with a behavioural interval-timer model.
module tb_sys_timer_tick_scheduler;

    localparam int          NUM_CH = 4;
    localparam int          DIV_W  = 16;
    localparam logic [31:0] PER    = 32'd99;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enable = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH*DIV_W-1:0] ch_div = '0;
    logic [2:0]              tmr_address;
    logic                    tmr_chipselect;
    logic                    tmr_write_n;
    logic [15:0]             tmr_writedata;
    logic [15:0]             tmr_readdata;
    logic                    tmr_irq;
    logic                    tick;
    logic [NUM_CH-1:0]       ch_event;
    logic [31:0]             tick_count;
    logic                    running;
    logic                    fault;

    sys_timer_tick_scheduler #(.PERIOD(PER), .NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .ch_div(ch_div),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq), .tick(tick),
        .ch_event(ch_event), .tick_count(tick_count), .running(running), .fault(fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural interval timer ----------------
    logic [15:0] m_pl, m_ph, m_rdata;
    logic        m_run, m_to, m_ito, m_cont;
    logic [31:0] m_cnt;
    logic        m_block_run = 1'b0;   // forces status RUN to read as 0

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pl <= '0; m_ph <= '0; m_rdata <= '0; m_run <= 1'b0; m_to <= 1'b0;
            m_ito <= 1'b0; m_cont <= 1'b0; m_cnt <= '0;
        end else begin
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= {m_ph, m_pl};
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= tmr_writedata[0];
                        m_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) begin
                            m_run <= 1'b1;
                            m_cnt <= {m_ph, m_pl};
                        end
                        if (tmr_writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: m_pl <= tmr_writedata;
                    3'd3: m_ph <= tmr_writedata;
                    default: ;
                endcase
            end
            m_rdata <= (tmr_chipselect && tmr_write_n && tmr_address == 3'd0) ?
                       {14'd0, m_run & ~m_block_run, m_to} : 16'h0000;
        end
    end
    assign tmr_readdata = m_rdata;
    assign tmr_irq      = m_to & m_ito;

    // ---------------- bus write log ----------------
    logic [2:0]  wa_q[$];
    logic [15:0] wd_q[$];
    always @(posedge clk) begin
        if (!reset && tmr_chipselect && !tmr_write_n) begin
            wa_q.push_back(tmr_address);
            wd_q.push_back(tmr_writedata);
            $display("bus write addr=%0d data=%04h", tmr_address, tmr_writedata);
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_q[$];
    int ev_cnt[NUM_CH];
    int stray = 0;

    typedef struct {
        logic [NUM_CH*DIV_W-1:0] div;
        logic [NUM_CH-1:0]       en;
        int                      nticks;
        logic [NUM_CH*8-1:0]     exp_ev;
    } vec_t;
    vec_t vecs[3];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (tick) tick_q.push_back(cyc);
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_event[i]) begin
                ev_cnt[i]++;
                if (!tick) stray++;
            end
        end
    endtask

    task automatic clear_stats();
        tick_q.delete();
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < NUM_CH; i++) ev_cnt[i] = 0;
        stray = 0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic wait_ticks(int n);
        int budget;
        budget = n * 100 + 300;
        while (tick_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
        if (tick_q.size() < n) begin
            total++;
            bad++;
            $display("FAIL wait_ticks: got %0d ticks, expected %0d", tick_q.size(), n);
        end
    endtask

    function automatic logic [31:0] wr_at(int i);
        if (i < wa_q.size()) return {13'd0, wa_q[i], wd_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_reset_values(string tag);
        check({tag, "_bus"}, {11'd0, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata},
              {11'd0, 3'd0, 1'b0, 1'b1, 16'h0000});
        check({tag, "_status"}, {25'd0, tick, ch_event, running, fault}, 32'd0);
        check({tag, "_tick_count"}, tick_count, 32'd0);
    endtask

    task automatic check_program_seq(string tag);
        check({tag, "_wr_pl"}, wr_at(0), {13'd0, 3'd2, PER[15:0]});
        check({tag, "_wr_ph"}, wr_at(1), {13'd0, 3'd3, PER[31:16]});
        check({tag, "_wr_ctrl"}, wr_at(2), {13'd0, 3'd1, 16'h0007});
    endtask

    initial begin
        vecs[0] = '{div: {16'd5, 16'd3, 16'd1, 16'd0}, en: 4'hF, nticks: 15,
                    exp_ev: {8'd3, 8'd5, 8'd15, 8'd15}};
        vecs[1] = '{div: {16'd8, 16'd6, 16'd4, 16'd2}, en: 4'hF, nticks: 12,
                    exp_ev: {8'd2, 8'd2, 8'd3, 8'd6}};
        vecs[2] = '{div: {16'd3, 16'd2, 16'd0, 16'd7}, en: 4'b0101, nticks: 9,
                    exp_ev: {8'd0, 8'd5, 8'd0, 8'd2}};

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        clear_stats();

        // Programming sequence, start latency, tick spacing
        ch_en = 4'hF;
        enable = 1'b1;
        step();
        check("first_write", {12'd0, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata},
              {12'd0, 3'd2, 1'b1, 1'b0, PER[15:0]});
        repeat (4) step();
        check("running_at_5", {31'd0, running}, 32'd0);
        step();
        check("running_at_6", {31'd0, running}, 32'd1);
        check_program_seq("prog");
        wait_ticks(5);
        check("tick_count_5", tick_count, 32'd5);
        for (int k = 1; k < 5 && k < tick_q.size(); k++)
            check($sformatf("tick_gap_%0d", k), tick_q[k] - tick_q[k-1], 32'd100);

        // Table-driven channel vectors
        for (int v = 0; v < 3; v++) begin
            do_reset();
            ch_div = vecs[v].div;
            ch_en  = vecs[v].en;
            enable = 1'b1;
            wait_ticks(vecs[v].nticks);
            for (int i = 0; i < NUM_CH; i++)
                check($sformatf("vec%0d_ch%0d_events", v, i), ev_cnt[i],
                      {24'd0, vecs[v].exp_ev[i*8 +: 8]});
            check($sformatf("vec%0d_coincident", v), stray, 32'd0);
        end

        // Randomized channels against ceil(n/max(div,1)) reference
        for (int r = 0; r < 4; r++) begin
            int n;
            int d[NUM_CH];
            do_reset();
            n = $urandom_range(3, 12);
            for (int i = 0; i < NUM_CH; i++) begin
                d[i] = $urandom_range(0, 6);
                ch_div[i*DIV_W +: DIV_W] = DIV_W'(d[i]);
                ch_en[i] = 1'($urandom_range(0, 3) != 0);
            end
            enable = 1'b1;
            wait_ticks(n);
            for (int i = 0; i < NUM_CH; i++) begin
                int dd, expv;
                dd = (d[i] == 0) ? 1 : d[i];
                expv = ch_en[i] ? (n + dd - 1) / dd : 0;
                check($sformatf("rand%0d_ch%0d_div%0d_n%0d", r, i, d[i], n), ev_cnt[i], expv);
            end
            check($sformatf("rand%0d_tick_count", r), tick_count, n);
        end

        // Channel enabled late: first event on the div-th tick after enable
        do_reset();
        ch_div = {16'd1, 16'd1, 16'd1, 16'd3};
        ch_en  = 4'b0000;
        enable = 1'b1;
        wait_ticks(2);
        ch_en = 4'b0001;
        wait_ticks(4);
        check("late_en_after_2", ev_cnt[0], 32'd0);
        wait_ticks(5);
        check("late_en_after_3", ev_cnt[0], 32'd1);

        // Start verification failure: three START attempts, then fault
        do_reset();
        m_block_run = 1'b1;
        enable = 1'b1;
        repeat (40) step();
        begin
            int nctrl = 0;
            for (int i = 0; i < wa_q.size(); i++)
                if (wa_q[i] == 3'd1 && wd_q[i] == 16'h0007) nctrl++;
            check("fault_ctrl_writes", nctrl, 32'd3);
        end
        check("fault_set", {30'd0, fault, running}, {30'd0, 1'b1, 1'b0});
        wa_q.delete();
        wd_q.delete();
        begin
            int cs_seen = 0;
            enable = 1'b0;
            repeat (10) begin step(); if (tmr_chipselect) cs_seen++; end
            enable = 1'b1;
            repeat (20) begin step(); if (tmr_chipselect) cs_seen++; end
            check("halt_bus_idle", cs_seen, 32'd0);
            check("halt_no_writes", wa_q.size(), 32'd0);
        end
        m_block_run = 1'b0;

        // enable drops in the same cycle as irq: ack first, then stop
        do_reset();
        enable = 1'b1;
        begin
            int budget = 400;
            while (!tmr_irq && budget > 0) begin step(); budget--; end
            check("irq_seen", {31'd0, tmr_irq}, 32'd1);
        end
        enable = 1'b0;
        wa_q.delete();
        wd_q.delete();
        step();
        check("prio_tick", {31'd0, tick}, 32'd1);
        repeat (6) step();
        check("prio_ack_write", wr_at(0), {13'd0, 3'd0, 16'h0000});
        check("prio_stop_write", wr_at(1), {13'd0, 3'd1, 16'h0008});
        check("prio_running", {31'd0, running}, 32'd0);
        check("prio_tick_count", tick_count, 32'd1);

        // Reset in ACK_WAIT, then full replay on re-enable
        do_reset();
        ch_en = 4'hF;
        ch_div = '0;
        enable = 1'b1;
        wait_ticks(1);
        step();
        reset = 1'b1;
        enable = 1'b0;
        #1;
        check_reset_values("ackwait_rst");
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        enable = 1'b1;
        repeat (6) step();
        check_program_seq("replay");
        check("replay_running", {31'd0, running}, 32'd1);

        // tick_count wraps at 2^32
        force dut.tick_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.tick_count_reg;
        wait_ticks(1);
        check("tick_count_wrap", tick_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_timer_tick_scheduler.md
# sys_timer_tick_scheduler

Avalon-MM master that owns the 16-bit register port of the Nios system interval timer. It programs the 32-bit period, starts the timer in continuous interrupt mode, verifies that it is running, acknowledges every timeout, and emits a one-cycle `tick` for each timeout. The ticks are fanned out to `NUM_CH` independent divider channels, so several hardware clients share one timer without any CPU involvement. It sits in the Qsys system between the timer's s1 slave and the fabric-side consumers.

## Interface
- `PERIOD`, default 32'h0007_A11F: timer load value (ticks every PERIOD+1 clocks); must be ≥ 16.
- `NUM_CH`, default 4: number of divider channels, 1–8.
- `DIV_W`, default 16: divider width per channel.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; 1 = start and keep timer running, 0 = stop it.
- `ch_en`  in  NUM_CH  per-channel enable.
- `ch_div`  in  NUM_CH*DIV_W  channel i divider in bits [i*DIV_W +: DIV_W]; 0 is treated as 1.
- `tmr_address`  out  3  to timer `address`.
- `tmr_chipselect`  out  1  to timer `chipselect`.
- `tmr_write_n`  out  1  to timer `write_n`.
- `tmr_writedata`  out  16  to timer `writedata`.
- `tmr_readdata`  in  16  from timer `readdata`.
- `tmr_irq`  in  1  from timer `irq`.
- `tick`  out  1  one-cycle pulse per acknowledged timeout.
- `ch_event`  out  NUM_CH  one-cycle pulse per channel division.
- `tick_count`  out  32  total ticks since reset; wraps at 2^32.
- `running`  out  1  timer verified running.
- `fault`  out  1  sticky; start verification failed.

## Operation
- Timer register map: 0 status (bit1 run, bit0 TO, any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Bus cycles:
  - Write: exactly one cycle with `tmr_chipselect`=1 and `tmr_write_n`=0. No waitrequest.
  - Read: drive `tmr_address` for one cycle with `tmr_chipselect`=1 and `tmr_write_n`=1; sample `tmr_readdata` on the following cycle.
  - Idle bus: `tmr_chipselect`=0, `tmr_write_n`=1.
- FSM sequence:
  - IDLE: wait for `enable`=1.
  - WR_PL: write PERIOD[15:0] to address 2.
  - WR_PH: write PERIOD[31:16] to address 3.
  - WR_CTRL: write 16'h0007 to address 1.
  - RD_STAT: read address 0.
  - CHK: sample `tmr_readdata`. If bit1=1, set `running` and go to RUN. If bit1=0, increment the retry count: when the count is below 3, go to WR_CTRL; otherwise set `fault` and go to HALT.
  - RUN: on `tmr_irq`=1, go to ACK. On `enable`=0, go to STOP.
  - ACK: write 16'h0000 to address 0, pulse `tick`, increment `tick_count`.
  - ACK_WAIT: ignore `tmr_irq` for one cycle (it drops at this cycle's edge), then go to RUN.
  - STOP: write 16'h0008 to address 1, clear `running`, go to IDLE.
  - HALT: bus idle until reset. `enable` is ignored.
- Priority and restart rules:
  - `tmr_irq` has priority over `enable`=0 in RUN. The pending tick is acknowledged first; STOP follows from RUN.
  - Retry count clears on entering WR_PL.
  - Re-enable after STOP replays the full sequence from WR_PL.
- Channels (on `tick` only):
  - If `ch_en[i]`=1: if cnt_i==0, pulse `ch_event[i]` in the same cycle as `tick` and reload cnt_i = max(div_i,1)−1; otherwise decrement cnt_i.
  - If `ch_en[i]`=0: cnt_i = max(div_i,1)−1 and no event. The first event therefore arrives on the div_i-th tick after enable.
  - `ch_div` changes take effect at the next reload.

## Timing
- Reset values:
  - Bus: `tmr_address`=0, `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_writedata`=0.
  - Status: `tick`=0, `ch_event`=0, `tick_count`=0, `running`=0, `fault`=0.
  - Internal: FSM in IDLE, all cnt_i=0, retry count 0.
- All outputs are registered.
- `enable` rise to the first timer write: 1 cycle. From IDLE to RUN: 6 cycles (WR_PL, WR_PH, WR_CTRL, RD_STAT, CHK).
- `tmr_irq` rise to `tick`: 1 cycle. Ticks are spaced exactly PERIOD+1 clocks apart.
- Reset asserted mid-sequence: outputs return to reset values immediately. Timer reprogramming on the next `enable` is idempotent.

## Structure
- Shared package `sys_timer_pkg`:
  - Register address constants.
  - Control bit constants.
  - FSM state enum.
- One sub-module, `tick_div_channel`: the per-channel counter with reload, instantiated NUM_CH times in a generate loop.

## Test plan
- Behavioural timer model, PERIOD=99, `enable` 0→1: writes 99/0/7 to addresses 2/3/1; `running`=1 six cycles after `enable`; `tick` every 100 cycles; `tick_count`=5 after 5 timeouts.
- `ch_div`={0,1,3,5}, all enabled, 15 ticks: `ch_event` counts are 15, 15, 5, 3. Events are coincident with `tick`.
- Timer model forces status bit1=0: exactly 3 WR_CTRL writes occur, then `fault`=1 and the bus stays idle; `enable` toggling has no effect until reset.
- `enable`→0 in the same cycle as `tmr_irq`: ACK write occurs, `tick` pulses, then the STOP write of 16'h0008 follows; `running`=0.
- `reset` pulsed during ACK_WAIT: all outputs return to reset values within the same cycle; re-enable replays the full programming sequence.
- `tick_count` preloaded via force to 32'hFFFF_FFFF, one tick: `tick_count` wraps to 0.
